dll_sar_sequencer: RTL and testbench

//  Drive side of the DLL binary-search loop. Filters raw phase-detector (PD) lead/lag samples by majority vote
//  and sequences the SAR code register: one step and one decision per code bit, MSB first.

---
 rtl/dll_sar_sequencer_pkg.sv | 22 ++
 rtl/dll_sar_sequencer_vote.sv | 53 +++++
 rtl/dll_sar_sequencer.sv | 171 +++++++++++++++++
 tb/tb_dll_sar_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_sar_sequencer_pkg.sv
// Shared definitions for the DLL SAR sequencer.
// Holds the sequencer state enum, the default loop parameters, and the
// resulting decision period at those defaults.
package dll_sar_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SETTLE,
        ST_VOTE,
        ST_DECIDE
    } seq_state_t;

    localparam int DEF_CODE_W     = 10;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_VOTE_N     = 4;
    localparam int DEF_LOSS_N     = 4;

    // Clock cycles from one decision to the next when pd_valid is held high.
    localparam int DEC_PERIOD = 1 + DEF_SETTLE_CYC + DEF_VOTE_N;

endpackage

// File: rtl/dll_sar_sequencer_vote.sv
// pd_vote_filter: majority vote over VOTE_N valid phase-detector samples.
// Ports:
//   clk4, rst_n   loop clock, async active-low reset
//   clr           holds the counters at zero (asserted outside the vote window)
//   pd_valid      pd_lead is valid this cycle
//   pd_lead       1 = feedback leads reference
//   ready         combinational: this cycle takes the final sample of the vote
//   decision      registered vote result (1 = lead), updated only when ready
module pd_vote_filter
    import dll_sar_sequencer_pkg::*;
#(
    parameter int VOTE_N = DEF_VOTE_N
) (
    input  logic clk4,
    input  logic rst_n,
    input  logic clr,
    input  logic pd_valid,
    input  logic pd_lead,
    output logic ready,
    output logic decision
);

    localparam int CNT_W = $clog2(VOTE_N + 1);

    logic [CNT_W-1:0] vote_cnt;
    logic [CNT_W-1:0] lead_cnt;
    logic [CNT_W-1:0] lead_tot;
    logic [CNT_W:0]   lead_x2;

    assign lead_tot = lead_cnt + CNT_W'(pd_lead);
    assign lead_x2  = {lead_tot, 1'b0};
    assign ready    = !clr && pd_valid && (vote_cnt == CNT_W'(VOTE_N - 1));

    always_ff @(posedge clk4 or negedge rst_n) begin
        if (!rst_n) begin
            vote_cnt <= '0;
            lead_cnt <= '0;
            decision <= 1'b0;
        end else if (clr) begin
            vote_cnt <= '0;
            lead_cnt <= '0;
        end else if (ready) begin
            // Strict majority: a tie resolves to lag.
            decision <= (lead_x2 > (CNT_W + 1)'(VOTE_N));
            vote_cnt <= '0;
            lead_cnt <= '0;
        end else if (pd_valid) begin
            vote_cnt <= vote_cnt + 1'b1;
            lead_cnt <= lead_tot;
        end
    end

endmodule

// File: rtl/dll_sar_sequencer.sv
// dll_sar_sequencer: drives the DLL binary search, then tracks and supervises lock.
// Ports:
//   clk4, rst_n        loop clock, async active-low reset
//   start              1-cycle conversion request (ignored while busy)
//   pd_valid, pd_lead  raw phase-detector samples
//   comp               voted decision for the SAR, valid with sar_step
//   sar_step, sar_clr  SAR advance / return-to-mid-code pulses
//   bit_idx            bit currently being decided
//   busy, done         conversion in progress / final-step pulse
//   locked             search complete and tracking within bounds
//   trk_up, trk_dn     tracking trim pulses
//
// state     | meaning
// IDLE      | waiting for start
// CLR       | SAR back to mid-code, bit pointer to MSB
// SETTLE    | delay line settling, PD samples discarded
// VOTE      | collecting VOTE_N valid PD samples
// DECIDE    | one decision: SAR step in search, trim pulse in tracking
module dll_sar_sequencer
    import dll_sar_sequencer_pkg::*;
#(
    parameter int CODE_W     = DEF_CODE_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int VOTE_N     = DEF_VOTE_N,
    parameter int LOSS_N     = DEF_LOSS_N
) (
    input  logic                      clk4,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      pd_valid,
    input  logic                      pd_lead,
    output logic                      comp,
    output logic                      sar_step,
    output logic                      sar_clr,
    output logic [$clog2(CODE_W)-1:0] bit_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      locked,
    output logic                      trk_up,
    output logic                      trk_dn
);

    localparam int BIT_W  = $clog2(CODE_W);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int LOSS_W = $clog2(LOSS_N + 1);

    localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(CODE_W - 1);
    localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_N);

    seq_state_t        state, state_nxt;
    logic              trk, trk_nxt;
    logic              locked_nxt;
    logic              last_dir, last_dir_nxt;
    logic [LOSS_W-1:0] loss_cnt, loss_nxt, loss_inc;
    logic [SET_W-1:0]  settle_cnt, settle_nxt;
    logic [BIT_W-1:0]  bit_idx_nxt;
    logic              vote_en;
    logic              vote_rdy;

    // A restart request in tracking pre-empts a vote finishing the same cycle,
    // so comp only ever changes on the way into DECIDE.
    assign vote_en = (state == ST_VOTE) && !(trk && start);
    assign busy    = (state != ST_IDLE) && !trk;

    pd_vote_filter #(
        .VOTE_N (VOTE_N)
    ) u_vote (
        .clk4     (clk4),
        .rst_n    (rst_n),
        .clr      (!vote_en),
        .pd_valid (pd_valid),
        .pd_lead  (pd_lead),
        .ready    (vote_rdy),
        .decision (comp)
    );

    always_ff @(posedge clk4 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            trk        <= 1'b0;
            locked     <= 1'b0;
            last_dir   <= 1'b0;
            loss_cnt   <= '0;
            settle_cnt <= '0;
            bit_idx    <= BIT_MSB;
        end else begin
            state      <= state_nxt;
            trk        <= trk_nxt;
            locked     <= locked_nxt;
            last_dir   <= last_dir_nxt;
            loss_cnt   <= loss_nxt;
            settle_cnt <= settle_nxt;
            bit_idx    <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        trk_nxt      = trk;
        locked_nxt   = locked;
        last_dir_nxt = last_dir;
        loss_nxt     = loss_cnt;
        loss_inc     = '0;
        settle_nxt   = settle_cnt;
        bit_idx_nxt  = bit_idx;
        sar_step     = 1'b0;
        sar_clr      = 1'b0;
        done         = 1'b0;
        trk_up       = 1'b0;
        trk_dn       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                sar_clr    = 1'b1;
                settle_nxt = SET_LOAD;
                state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) state_nxt = ST_VOTE;
                else                  settle_nxt = settle_cnt - 1'b1;
            end
            ST_VOTE: begin
                if (vote_rdy) state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                settle_nxt = SET_LOAD;
                state_nxt  = ST_SETTLE;
                if (!trk) begin
                    sar_step = 1'b1;
                    if (bit_idx != '0) begin
                        bit_idx_nxt = bit_idx - 1'b1;
                    end else begin
                        done       = 1'b1;
                        trk_nxt    = 1'b1;
                        locked_nxt = 1'b1;
                        loss_nxt   = '0;
                    end
                end else begin
                    trk_up       = comp;
                    trk_dn       = !comp;
                    last_dir_nxt = comp;
                    // loss_cnt == 0 marks the first tracking decision after a search.
                    loss_inc = (loss_cnt != '0 && comp == last_dir) ? loss_cnt + 1'b1 : LOSS_W'(1);
                    if (loss_inc == LOSS_MAX) begin
                        trk_nxt    = 1'b0;
                        locked_nxt = 1'b0;
                        loss_nxt   = '0;
                        state_nxt  = ST_CLR;
                    end else begin
                        loss_nxt = loss_inc;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (trk && start) begin
            trk_nxt    = 1'b0;
            locked_nxt = 1'b0;
            loss_nxt   = '0;
            state_nxt  = ST_CLR;
        end

        if (state_nxt == ST_CLR) bit_idx_nxt = BIT_MSB;
    end

endmodule

// File: tb/tb_dll_sar_sequencer.sv
module tb_dll_sar_sequencer;
    import dll_sar_sequencer_pkg::*;

    logic       clk4 = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pd_valid = 1'b0;
    logic       pd_lead = 1'b0;
    logic       comp, sar_step, sar_clr, busy, done, locked, trk_up, trk_dn;
    logic [3:0] bit_idx;

    always #5 clk4 = ~clk4;

    dll_sar_sequencer dut (
        .clk4     (clk4),
        .rst_n    (rst_n),
        .start    (start),
        .pd_valid (pd_valid),
        .pd_lead  (pd_lead),
        .comp     (comp),
        .sar_step (sar_step),
        .sar_clr  (sar_clr),
        .bit_idx  (bit_idx),
        .busy     (busy),
        .done     (done),
        .locked   (locked),
        .trk_up   (trk_up),
        .trk_dn   (trk_dn)
    );

    localparam int K_CLR  = 0;
    localparam int K_STEP = 1;
    localparam int K_UP   = 2;
    localparam int K_DN   = 3;
    localparam int SLOW_PERIOD = DEC_PERIOD + DEF_VOTE_N;

    typedef struct {
        int kind;
        int cval;
        int bidx;
        int dn;
        int gap;
    } evt_t;

    evt_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   step_cnt = 0;

    logic [39:0] nib_mix;
    logic [9:0]  exp_mix;
    logic [39:0] nib_all1;
    int          s0;

    always @(posedge clk4) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse the DUT emits must match the head of the expected queue.
    always @(negedge clk4) begin
        int   npulse;
        int   kind;
        evt_t e;
        if (rst_n) begin
            npulse = int'(sar_clr) + int'(sar_step) + int'(trk_up) + int'(trk_dn);
            if (npulse > 1) check("pulse_exclusive", npulse, 1);
            if (done && !sar_step) check("done_without_step", 0, 1);
            if (npulse == 1) begin
                kind = sar_clr ? K_CLR : sar_step ? K_STEP : trk_up ? K_UP : K_DN;
                if (kind == K_STEP) step_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_kind", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_kind", kind, e.kind);
                    if (e.kind == K_STEP) begin
                        check("step_comp", int'(comp), e.cval);
                        check("step_bit_idx", int'(bit_idx), e.bidx);
                        check("step_done", int'(done), e.dn);
                    end else if (e.kind == K_CLR) begin
                        check("clr_bit_idx", int'(bit_idx), e.bidx);
                    end else begin
                        check("trk_comp", int'(comp), e.cval);
                    end
                    if (e.gap != 0) check("evt_gap", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
            end
        end
    end

    task automatic push(input int kind, input int cval, input int bidx, input int dn, input int gap);
        evt_t e;
        e = '{kind, cval, bidx, dn, gap};
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic v, input logic l, input logic s);
        pd_valid = v;
        pd_lead  = l;
        start    = s;
        @(negedge clk4);
        #1;
    endtask

    // One decision: 2 settle cycles of misleading samples, 4 valid votes, DECIDE.
    task automatic dec_drive(input logic [3:0] nib, input logic expc, input bit slow, input logic s_glitch);
        tick(1'b1, !expc, s_glitch);
        tick(1'b1, !expc, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (slow) tick(1'b0, !expc, 1'b0);
            tick(1'b1, nib[i], 1'b0);
        end
        tick(1'b0, !expc, 1'b0);
    endtask

    task automatic dec_step(input logic [3:0] nib, input logic expc, input int bidx, input bit slow, input logic s_glitch);
        push(K_STEP, int'(expc), bidx, (bidx == 0) ? 1 : 0, slow ? SLOW_PERIOD : DEC_PERIOD);
        dec_drive(nib, expc, slow, s_glitch);
    endtask

    task automatic dec_trk(input logic [3:0] nib, input logic expc, input bit lose);
        push(expc ? K_UP : K_DN, int'(expc), 0, 0, DEC_PERIOD);
        if (lose) push(K_CLR, 0, 9, 0, 1);
        dec_drive(nib, expc, 1'b0, 1'b0);
    endtask

    task automatic conv(input logic [39:0] nibs, input logic [9:0] expc, input bit slow, input int glitch_bit);
        for (int b = 9; b >= 0; b--) begin
            dec_step(nibs[b*4 +: 4], expc[b], b, slow, (b == glitch_bit));
        end
    endtask

    // Issues start; returns in the cycle after CLR so the next call is the first settle cycle.
    task automatic begin_conv(input int gap);
        push(K_CLR, 0, 9, 0, gap);
        tick(1'b0, 1'b0, 1'b1);
        check("clr_level", int'(sar_clr), 1);
        check("clr_busy", int'(busy), 1);
        check("clr_locked", int'(locked), 0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        nib_mix  = {4'b1111, 4'b0111, 4'b0101, 4'b0001, 4'b0000,
                    4'b1011, 4'b1100, 4'b1000, 4'b1110, 4'b0011};
        exp_mix  = 10'b1100010010;
        nib_all1 = {40{1'b1}};

        repeat (3) @(negedge clk4);
        #1 rst_n = 1'b1;

        // Reset and idle.
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        check("idle_sar_step", int'(sar_step), 0);
        check("idle_sar_clr", int'(sar_clr), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_locked", int'(locked), 0);
        check("idle_trk_up", int'(trk_up), 0);
        check("idle_trk_dn", int'(trk_dn), 0);
        check("idle_comp", int'(comp), 0);
        check("idle_bit_idx", int'(bit_idx), 9);

        // Full conversion, all leads.
        begin_conv(0);
        check("conv_busy", int'(busy), 1);
        s0 = step_cnt;
        conv(nib_all1, 10'h3FF, 1'b0, -1);
        check("conv1_steps", step_cnt - s0, 10);
        check("conv1_locked", int'(locked), 1);
        check("conv1_busy", int'(busy), 0);

        // Tracking: alternating directions keep lock, then 4 leads lose it.
        dec_trk(4'b1111, 1'b1, 1'b0);
        dec_trk(4'b0000, 1'b0, 1'b0);
        dec_trk(4'b1110, 1'b1, 1'b0);
        dec_trk(4'b0001, 1'b0, 1'b0);
        check("trk_alt_locked", int'(locked), 1);
        dec_trk(4'b1111, 1'b1, 1'b0);
        dec_trk(4'b1111, 1'b1, 1'b0);
        dec_trk(4'b1111, 1'b1, 1'b0);
        check("trk_3same_locked", int'(locked), 1);
        dec_trk(4'b1111, 1'b1, 1'b1);
        check("loss_locked", int'(locked), 0);
        check("loss_busy", int'(busy), 1);
        tick(1'b0, 1'b0, 1'b0);
        s0 = step_cnt;
        conv(nib_mix, exp_mix, 1'b0, -1);
        check("reconv_steps", step_cnt - s0, 10);
        check("reconv_locked", int'(locked), 1);

        // Start while locked restarts; slow pd_valid; start mid-conversion is ignored.
        begin_conv(2);
        s0 = step_cnt;
        conv(nib_mix, exp_mix, 1'b1, 6);
        check("slow_steps", step_cnt - s0, 10);
        check("slow_locked", int'(locked), 1);

        // Reset during VOTE at bit_idx = 5.
        dec_trk(4'b0000, 1'b0, 1'b0);
        begin_conv(2);
        for (int b = 9; b >= 6; b--) dec_step(nib_mix[b*4 +: 4], exp_mix[b], b, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("pre_rst_bit_idx", int'(bit_idx), 5);
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_sar_step", int'(sar_step), 0);
        check("rst_sar_clr", int'(sar_clr), 0);
        check("rst_done", int'(done), 0);
        check("rst_comp", int'(comp), 0);
        check("rst_bit_idx", int'(bit_idx), 9);
        repeat (2) @(negedge clk4);
        #1 rst_n = 1'b1;
        s0 = step_cnt;
        repeat (30) tick(1'b1, 1'b1, 1'b0);
        check("post_rst_steps", step_cnt - s0, 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_bit_idx", int'(bit_idx), 9);
        check("pending_events", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
